// File: rtl/prog_sequencer.sv
// Run controller: resets the core into each of three programs in turn and reports cycle counts.
// Optional step-mode hold between programs when SEQ_STEP_EN is defined.
module prog_sequencer #(
   parameter int unsigned PC_W           = 10,
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned RESET_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4000,
   parameter int unsigned START0         = 0,
   parameter int unsigned START1         = 128,
   parameter int unsigned START2         = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             core_done,
`ifdef SEQ_STEP_EN
   input  logic             step,
`endif
   output logic             core_reset,
   output logic [PC_W-1:0]  core_start_pc,
   output logic [1:0]       prog_id,
   output logic             busy,
   output logic             res_vld,
   output logic [CNT_W-1:0] res_cycles,
   output logic             res_timeout,
   output logic             all_done,
   output logic [2:0]       timeout_mask
);

   localparam int unsigned RW = $clog2(RESET_CYCLES + 1);

   typedef enum logic [2:0] {
      StIdle,
      StRst,
      StRun,
      StGap,
`ifdef SEQ_STEP_EN
      StHold,
`endif
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       prog_q, prog_d;
   logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] res_cycles_q, res_cycles_d;
   logic             res_to_q, res_to_d;
   logic [2:0]       mask_q, mask_d;
   logic             done_acc, to_hit, start_acc;

   // cyc_q counts completed RUN cycles, so zero marks the first one (stale done masked)
   assign done_acc  = core_done && (cyc_q != '0);
   assign to_hit    = (cyc_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign start_acc = start && ((state_q == StIdle) || (state_q == StDone));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         prog_q       <= '0;
         rst_cnt_q    <= '0;
         cyc_q        <= '0;
         res_cycles_q <= '0;
         res_to_q     <= 1'b0;
         mask_q       <= '0;
      end else begin
         state_q      <= state_d;
         prog_q       <= prog_d;
         rst_cnt_q    <= rst_cnt_d;
         cyc_q        <= cyc_d;
         res_cycles_q <= res_cycles_d;
         res_to_q     <= res_to_d;
         mask_q       <= mask_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: if (start) state_d = StRst;
         StRst:          if (rst_cnt_q == RW'(1)) state_d = StRun;
         StRun:          if (done_acc || to_hit) state_d = StGap;
         StGap: begin
            if (prog_q == 2'd2) state_d = StDone;
`ifdef SEQ_STEP_EN
            else state_d = StHold;
`else
            else state_d = StRst;
`endif
         end
`ifdef SEQ_STEP_EN
         StHold:         if (step) state_d = StRst;
`endif
         default:        state_d = StIdle;
      endcase
   end

   always_comb begin
      prog_d       = prog_q;
      rst_cnt_d    = rst_cnt_q;
      cyc_d        = '0;
      res_cycles_d = res_cycles_q;
      res_to_d     = res_to_q;
      mask_d       = mask_q;
      if (start_acc) begin
         prog_d = 2'd0;
         mask_d = '0;
      end
      if (state_d == StRst && state_q != StRst) begin
         rst_cnt_d = RW'(RESET_CYCLES);
      end else if (state_q == StRst) begin
         rst_cnt_d = rst_cnt_q - RW'(1);
      end
      if (state_q == StRun) begin
         cyc_d = cyc_q + CNT_W'(1);
         if (done_acc) begin
            res_cycles_d = cyc_q + CNT_W'(1);
            res_to_d     = 1'b0;
         end else if (to_hit) begin
            res_cycles_d   = CNT_W'(TIMEOUT_CYCLES);
            res_to_d       = 1'b1;
            mask_d[prog_q] = 1'b1;
         end
      end
      if (state_q == StGap && prog_q != 2'd2) prog_d = prog_q + 2'd1;
   end

   always_comb begin
      core_reset = 1'b1;
      busy       = 1'b0;
      res_vld    = 1'b0;
      all_done   = 1'b0;
      unique case (state_q)
         StRst: busy = 1'b1;
         StRun: begin
            core_reset = 1'b0;
            busy       = 1'b1;
         end
         StGap: begin
            busy    = 1'b1;
            res_vld = 1'b1;
         end
`ifdef SEQ_STEP_EN
         StHold: busy = 1'b1;
`endif
         StDone: begin
            core_reset = 1'b0;
            all_done   = 1'b1;
         end
         default: ;
      endcase
      unique case (prog_q)
         2'd0:    core_start_pc = PC_W'(START0);
         2'd1:    core_start_pc = PC_W'(START1);
         default: core_start_pc = PC_W'(START2);
      endcase
   end

   assign prog_id      = prog_q;
   assign res_cycles   = res_cycles_q;
   assign res_timeout  = res_to_q;
   assign timeout_mask = mask_q;

endmodule
